// File: rtl/wb_asram_ctrl.sv
// wb_asram_ctrl
//   WISHBONE slave controller for asynchronous SRAM/ROM/IO devices.
//   NREG address regions, each with its own chip select, read/write wait
//   states, enable and write-protect bits. These are programmed through a
//   small configuration WISHBONE slave. Incrementing and wrapping bursts
//   (cti=010, bte) keep the chip select low between beats.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   wb_*                system bus slave: adr/dat/sel/cyc/stb/we/cti/bte in,
//                       dat/ack/err/rty out (rty tied low)
//   cfg_*               config slave: adr (word index), dat, cyc/stb/we in,
//                       dat/ack out
//   mem_*               external memory pins: addr, dout, din, drive (pad
//                       output enable), csn[NREG], oen, wen[3:0] (active low)
//
// Config word i: [3:0] rws, [7:4] wws, [8] en, [9] wp; other bits read 0.
module wb_asram_ctrl #(
  parameter int unsigned        NREG     = 3,
  parameter logic [NREG*12-1:0] REG_ADDR = {12'h400, 12'h200, 12'h000},
  parameter logic [NREG*12-1:0] REG_MASK = {12'hC00, 12'hE00, 12'hE00},
  parameter logic [3:0]         WS_RST   = 4'd2
) (
  input  logic            clk,
  input  logic            rst_n,
  // system WISHBONE slave
  input  logic [31:0]     wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  input  logic [3:0]      wb_sel_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  // config WISHBONE slave
  input  logic [2:0]      cfg_adr_i,
  input  logic [31:0]     cfg_dat_i,
  input  logic            cfg_cyc_i,
  input  logic            cfg_stb_i,
  input  logic            cfg_we_i,
  output logic [31:0]     cfg_dat_o,
  output logic            cfg_ack_o,
  // memory pins
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_dout,
  input  logic [31:0]     mem_din,
  output logic            mem_drive,
  output logic [NREG-1:0] mem_csn,
  output logic            mem_oen,
  output logic [3:0]      mem_wen
);

  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_ACCESS,
    S_HOLD,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  logic [9:0] cfg_q [NREG];
  logic [9:0] cfg_rd;
  logic       cfg_req;

  assign cfg_req = cfg_cyc_i & cfg_stb_i;

  always_comb begin
    cfg_rd = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (cfg_adr_i == 3'(i)) cfg_rd = cfg_q[i];
    end
  end

  // The ack drops for one cycle after every handshake so a master holding
  // stb sees one ack per transfer; the write lands with the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cfg_q[i] <= {1'b0, 1'b1, WS_RST, WS_RST};
      end
      cfg_ack_o <= 1'b0;
      cfg_dat_o <= '0;
    end else if (cfg_ack_o) begin
      cfg_ack_o <= 1'b0;
    end else if (cfg_req) begin
      cfg_ack_o <= 1'b1;
      cfg_dat_o <= {22'd0, cfg_rd};
      if (cfg_we_i) begin
        for (int unsigned i = 0; i < NREG; i++) begin
          if (cfg_adr_i == 3'(i)) cfg_q[i] <= cfg_dat_i[9:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Region decode (lowest index wins)
  // ---------------------------------------------------------------------
  logic          hit;
  logic [RW-1:0] hit_idx;
  logic [9:0]    hit_cfg;
  logic          req_err;
  logic [3:0]    req_ws;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_cfg = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!hit &&
          ((wb_adr_i[31:20] & REG_MASK[i*12 +: 12]) == REG_ADDR[i*12 +: 12])) begin
        hit     = 1'b1;
        hit_idx = RW'(i);
        hit_cfg = cfg_q[i];
      end
    end
  end

  assign req_err = !hit || !hit_cfg[8] || (wb_we_i && hit_cfg[9]);
  assign req_ws  = wb_we_i ? hit_cfg[7:4] : hit_cfg[3:0];

  // ---------------------------------------------------------------------
  // Latched transfer state
  // ---------------------------------------------------------------------
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [RW-1:0] reg_q;
  logic [3:0]    ws_q;
  logic [3:0]    cnt_q;
  logic [31:0]   next_adr;
  logic [NREG-1:0] csn_sel;

  // Burst address step: only the wrap field advances for wrapping bursts.
  always_comb begin
    next_adr = adr_q;
    case (wb_bte_i)
      2'b00:   next_adr        = adr_q + 32'd4;
      2'b01:   next_adr[3:2]   = adr_q[3:2] + 2'd1;
      2'b10:   next_adr[4:2]   = adr_q[4:2] + 3'd1;
      default: next_adr[5:2]   = adr_q[5:2] + 4'd1;
    endcase
  end

  always_comb begin
    csn_sel = '1;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (reg_q == RW'(i)) csn_sel[i] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    mem_csn   = '1;
    mem_oen   = 1'b1;
    mem_wen   = 4'hF;
    mem_drive = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) state_d = req_err ? S_ERR : S_ACCESS;
      end
      S_ERR: begin
        wb_err_o = wb_cyc_i;
        state_d  = S_IDLE;
      end
      S_ACCESS: begin
        mem_csn = csn_sel;
        if (we_q) begin
          mem_drive = 1'b1;
          mem_wen   = ~sel_q;
        end else begin
          mem_oen = 1'b0;
        end
        if (cnt_q == '0) state_d = we_q ? S_HOLD : S_ACK;
      end
      S_HOLD: begin
        mem_csn   = csn_sel;
        mem_drive = 1'b1;
        state_d   = S_ACK;
      end
      S_ACK: begin
        mem_csn  = csn_sel;
        wb_ack_o = wb_cyc_i;
        state_d  = (wb_cti_i == 3'b010) ? S_ACCESS : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Master abort overrides everything: release the pins next cycle.
    if (state_q != S_IDLE && !wb_cyc_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      reg_q    <= '0;
      ws_q     <= '0;
      cnt_q    <= '0;
      wb_dat_o <= '0;
    end else if (state_q == S_IDLE && state_d == S_ACCESS) begin
      adr_q <= {wb_adr_i[31:2], 2'b00};
      dat_q <= wb_dat_i;
      sel_q <= wb_sel_i;
      we_q  <= wb_we_i;
      reg_q <= hit_idx;
      ws_q  <= req_ws;
      cnt_q <= req_ws;
    end else if (state_q == S_ACK && state_d == S_ACCESS) begin
      // Next burst beat: same region and wait states, fresh data/lanes.
      adr_q <= next_adr;
      dat_q <= wb_dat_i;
      sel_q <= wb_sel_i;
      cnt_q <= ws_q;
    end else if (state_q == S_ACCESS && state_d != S_IDLE) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
      else if (!we_q)  wb_dat_o <= mem_din;
    end
  end

  assign mem_addr = adr_q;
  assign mem_dout = dat_q;
  assign wb_rty_o = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], cfg_dat_i[31:10]};

endmodule

// File: doc/wb_asram_ctrl.md
Name: wb_asram_ctrl

Overview:
- Native WISHBONE slave controller for asynchronous SRAM/ROM/IO devices.
- Decodes NREG parametrised address regions, each with its own chip select, programmable read/write wait states, enable and write-protect, set through a small config WISHBONE slave.
- Supports incrementing and wrapping bursts (cti/bte) without dropping chip select.
- Sits between the system WISHBONE bus and external parallel memory pins, directly and without an AHB/APB bridge.

Parameters:
- NREG, 3: number of decoded regions / chip selects (1..8).
- REG_ADDR, {12'h400,12'h200,12'h000}: NREG*12-bit concatenation. Region i base is compared against adr[31:20]; region 0 is in the LSBs.
- REG_MASK, {12'hC00,12'hE00,12'hE00}: NREG*12-bit concatenation of region masks.
- WS_RST, 4'd2: reset value of every read/write wait-state field.

Ports:
- clk in 1: system clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- wb_adr_i in 32: byte address.
- wb_dat_i in 32: write data.
- wb_sel_i in 4: byte lanes.
- wb_cyc_i, wb_stb_i, wb_we_i in 1 each: WISHBONE cycle, strobe, write enable.
- wb_cti_i in 3: cycle type identifier.
- wb_bte_i in 2: burst type extension.
- wb_dat_o out 32: registered read data.
- wb_ack_o, wb_err_o, wb_rty_o out 1 each: ack, error, retry. wb_rty_o is tied 0.
- cfg_adr_i in 3: config word index.
- cfg_dat_i in 32: config write data.
- cfg_cyc_i, cfg_stb_i, cfg_we_i in 1 each: config bus controls.
- cfg_dat_o out 32: config read data.
- cfg_ack_o out 1: config acknowledge.
- mem_addr out 32: memory address.
- mem_dout out 32: memory write data.
- mem_din in 32: memory read data.
- mem_drive out 1: 1 = drive data pads.
- mem_csn out NREG: active-low chip selects.
- mem_oen out 1: active-low output enable.
- mem_wen out 4: active-low per-byte write strobes.

Behaviour:
- Reset (async, asserted): every output goes to 0, except mem_csn = all 1, mem_oen = 1, mem_wen = 4'hF. FSM goes to IDLE. Config regs reset to {wp=0, en=1, wws=WS_RST, rws=WS_RST}. Reset asserted mid-access aborts the access with no ack.
- Config reg i (cfg_adr_i = i < NREG) bit fields:
  - [3:0] rws, read wait states.
  - [7:4] wws, write wait states.
  - [8] en.
  - [9] wp, write-protect.
  - Other bits read 0. Addresses >= NREG read 0 and ignore writes.
- Config handshake: cfg_ack_o is registered. It goes 1 in the cycle after cyc&stb is seen while ack=0, then forces 0 for one cycle. Write data is committed on the ack cycle. cfg_dat_o is registered alongside the ack.
- Decode: region i hits when (adr[31:20] & mask_i) == base_i. The lowest-index hit wins.
- FSM IDLE, when cyc&stb is seen:
  - Error case: no hit, or hit region has en=0, or write to a region with wp=1. Next cycle wb_err_o=1 for exactly 1 cycle, then IDLE. Memory pins are untouched.
  - Otherwise: latch adr (bits [1:0] forced 0), sel, dat, we, region and ws (rws or wws). Next state is ACCESS with cnt=ws, and mem_csn[region]=0.
- ACCESS:
  - Read: mem_oen=0.
  - Write: mem_drive=1, mem_wen=~sel.
  - cnt decrements each cycle. When cnt==0: a read captures mem_din into wb_dat_o and goes to ACK; a write goes to HOLD.
- HOLD (write only): mem_wen=4'hF, mem_drive and mem_csn are held for 1 cycle, then ACK.
- ACK: wb_ack_o=1 for exactly 1 cycle.
  - If cti seen in this cycle is 3'b010, the next beat begins: address advances +4 with wrap per bte (00 linear, 01 4-beat, 10 8-beat, 11 16-beat, wrapping on addr bits [3:2], [4:2], [5:2]). Next state is ACCESS, write data/sel are re-latched, and mem_csn stays low.
  - Otherwise mem_csn goes to 1 and the FSM returns to IDLE.
- Latency, stb first seen at cycle T, wait states ws:
  - Single read: ack at T+ws+2.
  - Single write: ack at T+ws+3.
  - Each further burst read beat: ws+2 cycles. Each further burst write beat: ws+3 cycles.
- Abort: cyc_i=0 in any non-IDLE state gives IDLE next cycle, all strobes and chip selects released, and no ack or err.
- Config changes during an access take effect from the next transaction, because wait states are latched at the start.
- Bursts keep the region latched on the first beat and are not re-decoded.
- wb_ack_o and wb_err_o are never 1 in the same cycle.

Test Plan:
1. Reset defaults; read at 0x4000_0010 with rws=2 and mem_din=0xDEADBEEF -> mem_csn=3'b011, mem_oen low for 3 cycles, wb_ack_o at T+4, wb_dat_o=0xDEADBEEF.
2. Write cfg reg1 = 0x0000_0130 (wws=3, rws=0, en=1); write 0x2000_0004 with sel=4'b0101 -> mem_wen=4'b1010 for 4 cycles, 1 HOLD cycle, ack at T+6, mem_dout=wb_dat_i.
3. Set wp on reg0; write to 0x0000_0000 -> wb_err_o 1 cycle at T+1, mem_csn stays all 1. Read of 0x8000_0000 (no hit) -> err as well.
4. 4-beat wrap read burst (cti=010, bte=01) at 0x4000_0008 -> mem_addr sequence 08, 0C, 00, 04; mem_csn stays low throughout; 4 acks; the cti=111 beat returns to IDLE.
5. Deassert cyc_i during ACCESS, and separately pulse rst_n low mid-write -> no ack; mem_csn/mem_wen back to all 1 next cycle (immediately for reset).
6. Back-to-back config read of reg 5 -> cfg_ack_o pattern 1,0,1; cfg_dat_o=0.
